// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU.
//   - Operation codes as produced by the ALU control decoder
//     ({funct7[5], funct3} for R/I ops, 0000 for address add, 1000 for branch compare).
//   - FSM state encoding, also visible on the unit's debug port.
//   - canon_op(): folds the 1xxx aliases onto their 0xxx operation.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int XLEN_DEF = 32;
  localparam int SHAMT_W  = $clog2(XLEN_DEF);

  // Only SUB and SRA give bit 3 a meaning; every other 1xxx code runs as 0xxx.
  function automatic logic [3:0] canon_op(input logic [3:0] f);
    if (f == ALU_SUB || f == ALU_SRA) return f;
    return {1'b0, f[2:0]};
  endfunction

endpackage

// File: rtl/alu_shift_step.sv
// One iteration of the iterative shifter: shifts a value by a small amount.
// Ports:
//   i_value  - working value
//   i_amount - shift distance for this step (never more than SHIFT_STEP)
//   i_left   - 1: shift left (SLL), 0: shift right
//   i_arith  - right shift fills with i_sign instead of 0 (SRA)
//   i_sign   - sign bit of the original operand
//   o_value  - shifted value
module alu_shift_step #(
  parameter int XLEN   = 32,
  parameter int STEP_W = 1
) (
  input  logic [XLEN-1:0]   i_value,
  input  logic [STEP_W-1:0] i_amount,
  input  logic              i_left,
  input  logic              i_arith,
  input  logic              i_sign,
  output logic [XLEN-1:0]   o_value
);

  logic [XLEN-1:0] w_fill_mask;

  always_comb begin
    // Ones in the vacated upper positions of a right shift.
    w_fill_mask = ~({XLEN{1'b1}} >> i_amount);
    if (i_left) begin
      o_value = i_value << i_amount;
    end else if (i_arith && i_sign) begin
      o_value = (i_value >> i_amount) | w_fill_mask;
    end else begin
      o_value = i_value >> i_amount;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshakes on input and output.
// Logic, add/sub and compares finish in one cycle; shifts iterate SHIFT_STEP
// bit positions per cycle.
//
// Handshake: an operation transfers on a rising edge where in_valid && in_ready
// && !flush; a result transfers on a rising edge where out_valid && out_ready.
// in_ready depends only on the state; out_valid/result/zero are registered and
// are held stable while out_ready is low.
//
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   flush           - synchronous abort; returns to IDLE, result/zero unchanged
//   in_valid/ready  - operation handshake; field/op_a/op_b sampled at accept
//   out_valid/ready - result handshake; result/zero valid while out_valid
//   dbg_state       - current FSM state (alu_pkg::state_t encoding)
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      field,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic [1:0]      dbg_state
);

  localparam int LSHAMT_W = $clog2(XLEN);
  localparam int STEP_W   = $clog2(SHIFT_STEP) + 1;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [XLEN-1:0]     r_result;
  logic [XLEN-1:0]     r_work;
  logic [LSHAMT_W-1:0] r_remain;
  logic                r_left;
  logic                r_arith;
  logic                r_sign;

  logic [3:0]          w_op;
  logic [XLEN-1:0]     w_alu;
  logic                w_is_shift;
  logic [LSHAMT_W-1:0] w_shamt;
  logic                w_shift_go;
  logic [STEP_W-1:0]   w_step;
  logic [LSHAMT_W-1:0] w_remain_nxt;
  logic [XLEN-1:0]     w_shifted;

  assign w_shamt    = op_b[LSHAMT_W-1:0];
  assign w_shift_go = w_is_shift && (w_shamt != '0);

  // Single-cycle operations. For shifts w_alu is op_a, which is the
  // result when shamt is zero.
  always_comb begin
    w_op       = canon_op(field);
    w_alu      = '0;
    w_is_shift = 1'b0;
    case (w_op)
      ALU_ADD:  w_alu = op_a + op_b;
      ALU_SUB:  w_alu = op_a - op_b;
      ALU_SLT:  w_alu = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU: w_alu = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      ALU_XOR:  w_alu = op_a ^ op_b;
      ALU_OR:   w_alu = op_a | op_b;
      ALU_AND:  w_alu = op_a & op_b;
      ALU_SLL, ALU_SRL, ALU_SRA: begin
        w_is_shift = 1'b1;
        w_alu      = op_a;
      end
      default:  w_alu = '0;
    endcase
  end

  // Step distance this cycle: min(SHIFT_STEP, remaining).
  always_comb begin
    if (r_remain < LSHAMT_W'(SHIFT_STEP)) begin
      w_step = r_remain[STEP_W-1:0];
    end else begin
      w_step = STEP_W'(SHIFT_STEP);
    end
    w_remain_nxt = r_remain - LSHAMT_W'(w_step);
  end

  alu_shift_step #(
    .XLEN   (XLEN),
    .STEP_W (STEP_W)
  ) u_shift_step (
    .i_value  (r_work),
    .i_amount (w_step),
    .i_left   (r_left),
    .i_arith  (r_arith),
    .i_sign   (r_sign),
    .o_value  (w_shifted)
  );

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (in_valid) w_state_nxt = w_shift_go ? ST_SHIFT : ST_DONE;
        ST_SHIFT: if (w_remain_nxt == '0) w_state_nxt = ST_DONE;
        ST_DONE:  if (out_ready) w_state_nxt = ST_IDLE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_work   <= '0;
      r_remain <= '0;
      r_left   <= 1'b0;
      r_arith  <= 1'b0;
      r_sign   <= 1'b0;
    end else if (flush) begin
      r_remain <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            if (w_shift_go) begin
              r_work   <= op_a;
              r_remain <= w_shamt;
              r_left   <= (w_op == ALU_SLL);
              r_arith  <= (w_op == ALU_SRA);
              r_sign   <= op_a[XLEN-1];
            end else begin
              r_result <= w_alu;
            end
          end
        end
        ST_SHIFT: begin
          r_work   <= w_shifted;
          r_remain <= w_remain_nxt;
          if (w_remain_nxt == '0) r_result <= w_shifted;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign result    = r_result;
  assign zero      = (r_result == '0);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

  localparam int XLEN = 32;
  localparam int STEP = 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b0;
  logic [3:0]      field = '0;
  logic [XLEN-1:0] op_a = '0;
  logic [XLEN-1:0] op_b = '0;
  logic            in_ready;
  logic            out_valid;
  logic [XLEN-1:0] result;
  logic            zero;
  logic [1:0]      dbg_state;

  int errors = 0;
  int checks = 0;
  logic [XLEN-1:0] exp_q[$];

  alu_exec_unit #(.XLEN(XLEN), .SHIFT_STEP(STEP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .field     (field),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [XLEN-1:0] ref_result(input logic [3:0] f, input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
    int unsigned sh;
    logic [2:0] k;
    sh = b[4:0];
    k  = f[2:0];
    if (f == 4'b1000) return a - b;
    if (f == 4'b1101) return XLEN'($signed(a) >>> sh);
    case (k)
      3'd0: return a + b;
      3'd1: return a << sh;
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return a >> sh;
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [3:0] f, input logic [XLEN-1:0] b);
    int sh;
    bit is_shift;
    sh = int'(b[4:0]);
    is_shift = (f[2:0] == 3'd1) || (f[2:0] == 3'd5);
    if (f == 4'b1000) is_shift = 1'b0;
    if (!is_shift || sh == 0) return 1;
    return 1 + (sh + STEP - 1) / STEP;
  endfunction

  // ---------------- driver ----------------
  // Presents one op (DUT assumed idle), waits for out_valid (bounded), holds
  // the result for 'hold' extra cycles, then completes the output transfer.
  // Returns at the falling edge after the transfer edge.
  task automatic run_op(input logic [3:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input int hold, output logic [XLEN-1:0] res, output logic z,
                        output int lat, output bit rdy_bad, output bit tmo);
    rdy_bad = 1'b0;
    tmo     = 1'b0;
    @(negedge clk);
    field = f; op_a = a; op_b = b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    field = 4'($urandom); op_a = $urandom; op_b = $urandom;
    lat = 1;
    while (!out_valid && lat < 200) begin
      if (in_ready) rdy_bad = 1'b1;
      @(negedge clk);
      lat++;
    end
    if (!out_valid) tmo = 1'b1;
    if (in_ready) rdy_bad = 1'b1;
    res = result;
    z   = zero;
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (result !== '0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero: got %b want 1", zero); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [3:0]      tf [10] = '{4'b0000, 4'b1000, 4'b1000, 4'b0010, 4'b0011,
                                 4'b1101, 4'b0101, 4'b0001, 4'b0001, 4'b1010};
    logic [XLEN-1:0] ta [10] = '{32'h5, 32'h5, 32'h1234_5678, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                 32'h8000_0000, 32'h8000_0000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hFFFF_FFFF};
    logic [XLEN-1:0] tb [10] = '{32'h3, 32'h3, 32'h1234_5678, 32'h1, 32'h1,
                                 32'd31, 32'd31, 32'h0, 32'h20, 32'h1};
    logic [XLEN-1:0] te [10] = '{32'h8, 32'h2, 32'h0, 32'h1, 32'h0,
                                 32'hFFFF_FFFF, 32'h1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h1};
    int              tl [10] = '{1, 1, 1, 1, 1, 32, 32, 1, 1, 1};
    logic [XLEN-1:0] res;
    logic z;
    int lat;
    bit rdy_bad, tmo;
    for (int i = 0; i < 10; i++) begin
      run_op(tf[i], ta[i], tb[i], 0, res, z, lat, rdy_bad, tmo);
      checks++; if (tmo) begin errors++; $display("FAIL dir%0d_timeout: out_valid absent after %0d cycles", i, lat); end
      checks++; if (res !== te[i]) begin errors++; $display("FAIL dir%0d_result: got %h want %h", i, res, te[i]); end
      checks++; if (z !== (te[i] == '0)) begin errors++; $display("FAIL dir%0d_zero: got %b want %b", i, z, (te[i] == '0)); end
      checks++; if (lat != tl[i]) begin errors++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, tl[i]); end
      checks++; if (rdy_bad) begin errors++; $display("FAIL dir%0d_in_ready: got 1 while busy want 0", i); end
    end
  endtask

  task automatic test_random();
    logic [3:0]      f;
    logic [XLEN-1:0] a, b, res, exp;
    logic z;
    int lat, exp_lat;
    bit rdy_bad, tmo;
    for (int i = 0; i < 40; i++) begin
      f = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) a = b;
      exp_q.push_back(ref_result(f, a, b));
      exp_lat = ref_latency(f, b);
      run_op(f, a, b, $urandom_range(0, 2), res, z, lat, rdy_bad, tmo);
      exp = exp_q.pop_front();
      checks++; if (tmo || res !== exp) begin errors++; $display("FAIL rnd%0d_result f=%b a=%h b=%h: got %h want %h", i, f, a, b, res, exp); end
      checks++; if (z !== (exp == '0)) begin errors++; $display("FAIL rnd%0d_zero: got %b want %b", i, z, (exp == '0)); end
      checks++; if (lat != exp_lat) begin errors++; $display("FAIL rnd%0d_latency f=%b: got %0d want %0d", i, f, lat, exp_lat); end
      checks++; if (rdy_bad) begin errors++; $display("FAIL rnd%0d_in_ready: got 1 while busy want 0", i); end
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    field = 4'b0000; op_a = 32'd7; op_b = 32'd9; in_valid = 1'b1;
    @(negedge clk);
    // Offer a different op while the result is stalled; it must not be taken.
    field = 4'b0100; op_a = 32'h1; op_b = 32'h1;
    for (int c = 0; c < 5; c++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp%0d_out_valid: got %b want 1", c, out_valid); end
      checks++; if (result !== 32'd16) begin errors++; $display("FAIL bp%0d_result: got %h want 00000010", c, result); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp%0d_in_ready: got %b want 0", c, in_ready); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
      $display("FAIL bp_release: got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || result !== 32'h0 || zero !== 1'b1) begin errors++;
      $display("FAIL bp_next_op: got v=%b r=%h z=%b want 1/00000000/1", out_valid, result, zero); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    logic [XLEN-1:0] res;
    logic z;
    int lat;
    bit rdy_bad, tmo, seen;
    run_op(4'b0110, 32'h0F, 32'hF0, 0, res, z, lat, rdy_bad, tmo);
    checks++; if (res !== 32'hFF) begin errors++; $display("FAIL fl_setup: got %h want 000000ff", res); end
    // Long shift, flushed on its fourth cycle.
    @(negedge clk);
    field = 4'b0001; op_a = 32'h1; op_b = 32'd20; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (dbg_state !== 2'd1 || in_ready !== 1'b0) begin errors++;
      $display("FAIL fl_in_shift: got state=%0d in_ready=%b want 1/0", dbg_state, in_ready); end
    flush = 1'b1;
    field = 4'b0000; op_a = 32'd1; op_b = 32'd1; in_valid = 1'b1;
    @(negedge clk);
    checks++; if (dbg_state !== 2'd0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++;
      $display("FAIL fl_idle: got state=%0d in_ready=%b out_valid=%b want 0/1/0", dbg_state, in_ready, out_valid); end
    checks++; if (result !== 32'hFF) begin errors++; $display("FAIL fl_result_kept: got %h want 000000ff", result); end
    // flush together with in_valid in IDLE: nothing accepted.
    @(negedge clk);
    checks++; if (dbg_state !== 2'd0 || out_valid !== 1'b0) begin errors++;
      $display("FAIL fl_no_accept: got state=%0d out_valid=%b want 0/0", dbg_state, out_valid); end
    flush = 1'b0; in_valid = 1'b0;
    seen = 1'b0;
    repeat (30) begin @(negedge clk); if (out_valid) seen = 1'b1; end
    checks++; if (seen) begin errors++; $display("FAIL fl_no_output: got out_valid=1 want 0"); end
    run_op(4'b0111, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, res, z, lat, rdy_bad, tmo);
    checks++; if (res !== 32'h00F0_00F0 || lat != 1) begin errors++;
      $display("FAIL fl_after_and: got %h lat %0d want 00f000f0 lat 1", res, lat); end
    // flush while the result is being taken: returns to IDLE, result unchanged.
    @(negedge clk);
    field = 4'b0000; op_a = 32'd40; op_b = 32'd2; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b0;
    checks++; if (dbg_state !== 2'd0 || out_valid !== 1'b0 || result !== 32'd42) begin errors++;
      $display("FAIL fl_done: got state=%0d out_valid=%b result=%h want 0/0/0000002a", dbg_state, out_valid, result); end
  endtask

  task automatic test_async_reset();
    logic [XLEN-1:0] res;
    logic z;
    int lat;
    bit rdy_bad, tmo;
    @(negedge clk);
    field = 4'b1000; op_a = 32'd10; op_b = 32'd3; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || result !== 32'd7) begin errors++;
      $display("FAIL ar_done: got v=%b r=%h want 1/00000007", out_valid, result); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
      $display("FAIL ar_immediate: got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
    checks++; if (result !== '0 || zero !== 1'b1) begin errors++;
      $display("FAIL ar_result: got %h zero=%b want 00000000/1", result, zero); end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(4'b0100, 32'hAAAA_AAAA, 32'h5555_5555, 0, res, z, lat, rdy_bad, tmo);
    checks++; if (tmo || res !== 32'hFFFF_FFFF || z !== 1'b0) begin errors++;
      $display("FAIL ar_after_xor: got %h zero=%b want ffffffff/0", res, z); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
